// File: rtl/lifo_stack_pkg.sv
// Shared constants, op encodings and a depth helper for the LIFO stack.
// Optional build macro used by this slice: STACK_ERR_EN (sticky error flag).
package stack_pkg;

    localparam int W_DEF = 8;
    localparam int H_DEF = 3;
    localparam int DEPTH = 2 ** H_DEF;

    // Count/pointer needs one extra bit so that "full" (== DEPTH) is representable.
    typedef logic [H_DEF:0] cnt_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    function automatic int depth_of(input int h);
        return 2 ** h;
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Push/pop request and status bundle between a stack user (master) and the stack (slave).
// The err member only exists when STACK_ERR_EN is defined.
interface lifo_stack_if
    import stack_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic         en;
    logic         rw;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         full;
    logic         empty;

`ifdef STACK_ERR_EN
    logic         err;

    modport master (
        output en, rw, data_in,
        input  data_out, full, empty, err
    );

    modport slave (
        input  en, rw, data_in,
        output data_out, full, empty, err
    );
`else
    modport master (
        output en, rw, data_in,
        input  data_out, full, empty
    );

    modport slave (
        input  en, rw, data_in,
        output data_out, full, empty
    );
`endif

endinterface

// File: rtl/lifo_stack_ram.sv
// DEPTH x W storage for the LIFO: synchronous write, synchronous clear, registered read.
// stack_mem keeps its name so benches can observe it hierarchically.
module stack_ram
    import stack_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int H = H_DEF
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         we,
    input  logic [H-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [H-1:0] raddr,
    output logic [W-1:0] rdata
);

    localparam int D = depth_of(H);

    logic [W-1:0] stack_mem [0:D-1];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!clear) begin
            for (int i = 0; i < D; i++) begin
                stack_mem[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                stack_mem[waddr] <= wdata;
            end
            // Popped entries are left in place; only the read register moves.
            if (re) begin
                rdata_q <= stack_mem[raddr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack top: occupancy count, full/empty decode and push/pop qualification.
// Define STACK_ERR_EN to add a sticky err flag for ignored push-when-full / pop-when-empty.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int H = H_DEF
) (
    input  logic         clk,
    input  logic         clear,
    lifo_stack_if.slave  bus
);

    localparam int         D        = depth_of(H);
    localparam logic [H:0] CNT_FULL = (H+1)'(D);

    logic [H:0]   cnt_q;
    logic [H:0]   cnt_d;
    logic         push_ok;
    logic         pop_ok;
    logic [H-1:0] waddr;
    logic [H-1:0] raddr;
    logic [W-1:0] rdata;

    assign bus.full  = (cnt_q == CNT_FULL);
    assign bus.empty = (cnt_q == '0);

    always_comb begin
        push_ok = bus.en && (bus.rw == OP_PUSH) && !bus.full;
        pop_ok  = bus.en && (bus.rw == OP_POP)  && !bus.empty;
        cnt_d   = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + (H+1)'(1);
        end else if (pop_ok) begin
            cnt_d = cnt_q - (H+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Low H bits wrap correctly for the top entry: cnt==DEPTH reads index DEPTH-1.
    assign waddr = cnt_q[H-1:0];
    assign raddr = cnt_q[H-1:0] - H'(1);

    stack_ram #(
        .W (W),
        .H (H)
    ) u_ram (
        .clk   (clk),
        .clear (clear),
        .we    (push_ok),
        .waddr (waddr),
        .wdata (bus.data_in),
        .re    (pop_ok),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.data_out = rdata;

`ifdef STACK_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (bus.en && (bus.rw == OP_PUSH) && bus.full) begin
            err_d = 1'b1;
        end
        if (bus.en && (bus.rw == OP_POP) && bus.empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: directed fill/drain/overflow/underflow/hold, then random traffic.
// A queue-based stack model produces expected outputs; a negedge monitor compares them.
module tb_lifo_stack;

    localparam int DEP = 8;

    typedef struct {
        string      tag;
        logic [7:0] dout;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    logic clk;
    logic clear;

    lifo_stack_if bus_if ();

    lifo_stack dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       exp_q [$];
    logic [7:0] model_stk [$];
    logic [7:0] model_mem [0:DEP-1];
    logic [7:0] model_dout;
    logic       model_err;
    int         n_cmp;
    int         n_bad;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, checked at the following negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp({e.tag, ".data_out"}, bus_if.data_out, e.dout);
                cmp({e.tag, ".full"},  {7'd0, bus_if.full},  {7'd0, e.full});
                cmp({e.tag, ".empty"}, {7'd0, bus_if.empty}, {7'd0, e.empty});
`ifdef STACK_ERR_EN
                cmp({e.tag, ".err"},   {7'd0, bus_if.err},   {7'd0, e.err});
`endif
            end
        end
    end

    task automatic model_reset();
        model_stk.delete();
        for (int i = 0; i < DEP; i++) model_mem[i] = 8'h00;
        model_dout = 8'h00;
        model_err  = 1'b0;
    endtask

    // Apply one cycle of stimulus, update the model, queue the expectation, advance one clock.
    task automatic step(input logic c, input logic e, input logic r, input logic [7:0] d,
                        input string tag);
        exp_t x;
        clear          = c;
        bus_if.en      = e;
        bus_if.rw      = r;
        bus_if.data_in = d;
        if (!c) begin
            model_reset();
        end else if (e) begin
            if (r) begin
                if (model_stk.size() < DEP) begin
                    model_mem[model_stk.size()] = d;
                    model_stk.push_back(d);
                end else begin
                    model_err = 1'b1;
                end
            end else begin
                if (model_stk.size() > 0) model_dout = model_stk.pop_back();
                else                      model_err  = 1'b1;
            end
        end
        x.tag   = tag;
        x.dout  = model_dout;
        x.full  = (model_stk.size() == DEP);
        x.empty = (model_stk.size() == 0);
        x.err   = model_err;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        int bad_idx;
        bad_idx = -1;
        for (int i = 0; i < DEP; i++) begin
            if (dut.u_ram.stack_mem[i] !== model_mem[i] && bad_idx < 0) bad_idx = i;
        end
        n_cmp++;
        if (bad_idx >= 0) begin
            n_bad++;
            $display("FAIL %s: stack_mem[%0d] got 0x%02h, expected 0x%02h", tag, bad_idx,
                     dut.u_ram.stack_mem[bad_idx], model_mem[bad_idx]);
        end
    endtask

    logic [7:0] fill_vals [0:7];

    initial begin
        int budget;
        logic bias;
        n_cmp = 0;
        n_bad = 0;
        fill_vals = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
        model_reset();
        clear          = 1'b0;
        bus_if.en      = 1'b0;
        bus_if.rw      = 1'b0;
        bus_if.data_in = 8'h00;
        @(negedge clk);
        #1;

        step(1'b0, 1'b0, 1'b0, 8'h00, "reset");
        check_mem("reset_mem");

        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, fill_vals[i], $sformatf("fill%0d", i));
        check_mem("fill_mem");

        step(1'b1, 1'b1, 1'b1, 8'hFF, "overflow");
        check_mem("overflow_mem");

        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'h5A, $sformatf("drain%0d", i));
        step(1'b1, 1'b1, 1'b0, 8'h5A, "underflow");
        check_mem("drain_mem");

        step(1'b1, 1'b1, 1'b1, 8'hAA, "push_aa");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, i[0], 8'($urandom), $sformatf("hold%0d", i));
        check_mem("hold_mem");
        step(1'b0, 1'b1, 1'b1, 8'h33, "clear");
        check_mem("clear_mem");

        for (int i = 0; i < 400; i++) begin
            bias = ((i / 50) % 2) == 0;
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0),
                 bias ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3),
                 8'($urandom),
                 $sformatf("rand%0d", i));
            if (i % 10 == 0) check_mem($sformatf("rand_mem%0d", i));
        end

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_scoreboard: %0d records left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
